sobel_stream: RTL

//  Streaming 3x3 Sobel edge detector for raster-order pixel streams. Holds two

---
 rtl/sobel_pkg.sv | 14 +
 rtl/sobel_linebuf.sv | 20 ++
 rtl/sobel_stream.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths and arithmetic helpers for the Sobel stream.
package sobel_pkg;
    localparam int PIX_W_DEF = 8;
    localparam int GRAD_W = PIX_W_DEF + 3;
    localparam int MAG_W = PIX_W_DEF + 4;

    function automatic int abs_s(input int grad);
        return (grad < 0) ? -grad : grad;
    endfunction

    function automatic int sat_u(input int mag, input int out_w);
        return (mag > (1 << out_w) - 1) ? (1 << out_w) - 1 : mag;
    endfunction
endpackage

// File: rtl/sobel_linebuf.sv
// sobel_linebuf: one image line of pixels, 1R1W on a shared address.
// Asynchronous read returns the old word before the same-cycle write lands.
module sobel_linebuf #(
    parameter int DEPTH = 640,
    parameter int W = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk)
        if (i_en) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel |Gx|+|Gy| with saturation or threshold.
// Three stages (window, gradients, magnitude); a stalled sink freezes all of them.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int OUT_W = 8,
    parameter int IMG_W = 640,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [OUT_W-1:0] thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic [OUT_W-1:0] out_pix
);
    localparam int G_W = PIX_W + 3;
    localparam int M_W = PIX_W + 4;
    localparam int AW = $clog2(IMG_W);

    logic             w_stall, w_acc, w_last_col;
    logic [CNT_W-1:0] r_col, r_row, w_col, w_row;
    logic [PIX_W-1:0] w_mid, w_top;
    logic [PIX_W-1:0] r_win [9];
    logic             r_v1, r_sof1, r_bord1, r_mode1;
    logic [OUT_W-1:0] r_th1;
    logic signed [G_W-1:0] w_e [9];
    logic signed [G_W-1:0] w_gx, w_gy, r_gx, r_gy;
    logic             r_v2, r_sof2, r_bord2, r_mode2;
    logic [OUT_W-1:0] r_th2;
    logic [M_W-1:0]   w_mag;
    logic [OUT_W-1:0] w_res;

    assign w_stall = out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_acc = in_valid && in_ready;
    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? '0 : r_row;
    assign w_last_col = (w_col == CNT_W'(IMG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            r_col <= w_last_col ? '0 : w_col + 1'b1;
            r_row <= (w_last_col && w_row != '1) ? w_row + 1'b1 : w_row;
        end
    end

    // lb0 holds the previous row, lb1 the row before that
    sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W), .AW(AW)) u_lb0 (
        .clk(clk), .i_en(w_acc), .i_addr(w_col[AW-1:0]), .i_wdata(in_pix), .o_rdata(w_mid)
    );
    sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W), .AW(AW)) u_lb1 (
        .clk(clk), .i_en(w_acc), .i_addr(w_col[AW-1:0]), .i_wdata(w_mid), .o_rdata(w_top)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '{default: '0};
            r_v1 <= 1'b0;
            r_sof1 <= 1'b0;
            r_bord1 <= 1'b0;
            r_mode1 <= 1'b0;
            r_th1 <= '0;
        end else if (!w_stall) begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_top;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_mid;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= in_pix;
                r_sof1 <= in_sof;
                r_bord1 <= (w_row < 2) || (w_col < 2);
                r_mode1 <= mode;
                r_th1 <= thresh;
            end
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_ext
        assign w_e[i] = G_W'(r_win[i]);
    end

    assign w_gx = (w_e[2] + (w_e[5] <<< 1) + w_e[8]) - (w_e[0] + (w_e[3] <<< 1) + w_e[6]);
    assign w_gy = (w_e[0] + (w_e[1] <<< 1) + w_e[2]) - (w_e[6] + (w_e[7] <<< 1) + w_e[8]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_sof2 <= 1'b0;
            r_bord2 <= 1'b0;
            r_mode2 <= 1'b0;
            r_th2 <= '0;
            r_gx <= '0;
            r_gy <= '0;
        end else if (!w_stall) begin
            r_v2 <= r_v1;
            r_sof2 <= r_sof1;
            r_bord2 <= r_bord1;
            r_mode2 <= r_mode1;
            r_th2 <= r_th1;
            r_gx <= w_gx;
            r_gy <= w_gy;
        end
    end

    assign w_mag = M_W'(abs_s(int'(r_gx)) + abs_s(int'(r_gy)));
    assign w_res = r_bord2 ? '0
                 : r_mode2 ? ((int'(w_mag) >= int'(r_th2)) ? '1 : '0)
                 : OUT_W'(sat_u(int'(w_mag), OUT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof <= 1'b0;
            out_pix <= '0;
        end else if (!w_stall) begin
            out_valid <= r_v2;
            out_sof <= r_sof2;
            out_pix <= w_res;
        end
    end
endmodule
